// File: rtl/w_bcd_converter.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Conversions start on in_valid, or automatically when w_in changes if AUTO is set.
module w_bcd_converter #(
    parameter int IN_W   = 5,
    parameter int DIGITS = 2,
    parameter bit AUTO   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_W-1:0]       w_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [3:0]            count1,
    output logic [3:0]            count2,
    output logic [4*DIGITS-1:0]   bcd_all,
    output logic                  busy,
    output logic                  done
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_W > 1) ? $clog2(IN_W) : 1;

    if ((10 ** DIGITS) <= (2 ** IN_W) - 1 || DIGITS < 2) begin : g_bad_params
        $error("w_bcd_converter: DIGITS too small for IN_W");
    end

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IN_W-1:0]   bin;
    logic [IN_W-1:0]   last_w;
    logic [BW-1:0]     bcd;
    logic [BW-1:0]     bcd_adj;
    logic [BW-1:0]     bcd_shift;
    logic [BW-1:0]     bcd_q;
    logic [CW-1:0]     bitcnt;
    logic              start;
    logic              last_bit;

    // add-3 correction on every nibble before the shift
    always_comb begin
        bcd_adj = bcd;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    assign bcd_shift = {bcd_adj[BW-2:0], bin[IN_W-1]};
    assign last_bit  = (bitcnt == CW'(IN_W - 1));

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        start      = in_valid || (AUTO && (w_in != last_w));
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (start) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            bin    <= '0;
            last_w <= '0;
            bcd    <= '0;
            bcd_q  <= '0;
            bitcnt <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin    <= w_in;
                        last_w <= w_in;
                        bcd    <= '0;
                        bitcnt <= '0;
                    end
                end
                SHIFT: begin
                    bcd    <= bcd_shift;
                    bin    <= bin << 1;
                    bitcnt <= bitcnt + CW'(1);
                    if (last_bit) begin
                        bcd_q <= bcd_shift;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bcd_all = bcd_q;
    assign count1  = bcd_q[3:0];
    assign count2  = bcd_q[7:4];

endmodule

// File: tb/tb_w_bcd_converter.sv
// Directed bench for w_bcd_converter: one manual-start (AUTO=0) and one auto-start (AUTO=1) instance.
module tb_w_bcd_converter;
    localparam int IN_W = 5;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] mw, aw;
    logic       mv, av;
    logic       m_rdy, m_busy, m_done, a_rdy, a_busy, a_done;
    logic [3:0] m_c1, m_c2, a_c1, a_c2;
    logic [7:0] m_all, a_all;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_m, exp_a;

    always #5 clk = ~clk;

    w_bcd_converter #(.IN_W(IN_W), .DIGITS(2), .AUTO(1'b0)) u_man (
        .clk(clk), .reset(reset), .w_in(mw), .in_valid(mv), .in_ready(m_rdy),
        .count1(m_c1), .count2(m_c2), .bcd_all(m_all), .busy(m_busy), .done(m_done)
    );

    w_bcd_converter #(.IN_W(IN_W), .DIGITS(2), .AUTO(1'b1)) u_auto (
        .clk(clk), .reset(reset), .w_in(aw), .in_valid(av), .in_ready(a_rdy),
        .count1(a_c1), .count2(a_c2), .bcd_all(a_all), .busy(a_busy), .done(a_done)
    );

    typedef struct {
        logic [4:0] w;
        logic [3:0] c2;
        logic [3:0] c1;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Called just after the accept edge; returns edges until done (0 on timeout)
    // and whether busy stayed high and outputs held their previous value meanwhile.
    task automatic wait_done(input bit sel, input logic [7:0] prev, output int n, output bit hold_ok);
        n = 0;
        hold_ok = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (sel ? a_done : m_done) begin
                n = i;
                break;
            end
            if ((sel ? a_all : m_all) != prev || !(sel ? a_busy : m_busy)) hold_ok = 1'b0;
        end
    endtask

    task automatic run_conv(input bit sel, input int w, input int c2, input int c1, input string nm);
        int n;
        bit hold_ok;
        logic [7:0] prev;
        prev = sel ? exp_a : exp_m;
        @(negedge clk);
        if (sel) aw = 5'(w);
        else begin
            mw = 5'(w);
            mv = 1'b1;
        end
        @(posedge clk); #1;
        mv = 1'b0;
        chk({nm, " accept_busy"}, int'(sel ? a_busy : m_busy), 1);
        wait_done(sel, prev, n, hold_ok);
        chk({nm, " latency"}, n, IN_W);
        chk({nm, " hold"}, int'(hold_ok), 1);
        chk({nm, " count2"}, int'(sel ? a_c2 : m_c2), c2);
        chk({nm, " count1"}, int'(sel ? a_c1 : m_c1), c1);
        chk({nm, " bcd_all"}, int'(sel ? a_all : m_all), c2 * 16 + c1);
        if (sel) exp_a = 8'(c2 * 16 + c1);
        else exp_m = 8'(c2 * 16 + c1);
    endtask

    initial begin
        int  n;
        bit  hold_ok;
        bit  idle_ok;

        vecs[0] = '{5'd0,  4'd0, 4'd0};
        vecs[1] = '{5'd9,  4'd0, 4'd9};
        vecs[2] = '{5'd10, 4'd1, 4'd0};
        vecs[3] = '{5'd19, 4'd1, 4'd9};
        vecs[4] = '{5'd20, 4'd2, 4'd0};
        vecs[5] = '{5'd25, 4'd2, 4'd5};
        vecs[6] = '{5'd7,  4'd0, 4'd7};
        vecs[7] = '{5'd30, 4'd3, 4'd0};
        vecs[8] = '{5'd15, 4'd1, 4'd5};
        vecs[9] = '{5'd11, 4'd1, 4'd1};

        reset = 1'b1;
        mw = '0; aw = '0; mv = 1'b0; av = 1'b0;
        exp_m = '0; exp_a = '0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst m_all", int'(m_all), 0);
        chk("rst a_all", int'(a_all), 0);
        chk("rst done", int'(m_done | a_done), 0);
        chk("rst busy", int'(m_busy | a_busy), 0);
        chk("rst ready", int'(m_rdy & a_rdy), 1);
        @(negedge clk);
        reset = 1'b0;
        idle_ok = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            if (m_busy || a_busy || m_done || a_done || !a_rdy) idle_ok = 1'b0;
        end
        chk("no start when w_in==last_w", int'(idle_ok), 1);

        // 31 on manual instance, done is a single-cycle pulse
        run_conv(1'b0, 31, 3, 1, "man31");
        chk("man31 ready_in_done", int'(m_rdy), 1);
        @(posedge clk); #1;
        chk("man31 done_one_cycle", int'(m_done), 0);

        for (int i = 0; i < 10; i++)
            run_conv(1'b0, int'(vecs[i].w), int'(vecs[i].c2), int'(vecs[i].c1),
                     $sformatf("vec%0d_w%0d", i, vecs[i].w));

        // auto sweep 1..31
        for (int w = 1; w < 32; w++)
            run_conv(1'b1, w, w / 10, w % 10, $sformatf("sweep_w%0d", w));

        // change during SHIFT is picked up after completion
        @(negedge clk);
        aw = 5'd9;
        @(posedge clk); #1;
        chk("chg accept_busy", int'(a_busy), 1);
        @(posedge clk); #1;
        aw = 5'd10;
        wait_done(1'b1, exp_a, n, hold_ok);
        chk("chg first latency", n, IN_W - 1);
        chk("chg first hold", int'(hold_ok), 1);
        chk("chg first value", int'(a_all), 8'h09);
        chk("chg ready_in_done", int'(a_rdy), 1);
        @(posedge clk); #1;
        chk("chg auto restart", int'(a_busy), 1);
        wait_done(1'b1, 8'h09, n, hold_ok);
        chk("chg second latency", n, IN_W);
        chk("chg second value", int'(a_all), 8'h10);
        exp_a = 8'h10;

        // in_valid together with a change: exactly one conversion
        @(negedge clk);
        aw = 5'd12;
        av = 1'b1;
        @(posedge clk); #1;
        av = 1'b0;
        chk("dual accept_busy", int'(a_busy), 1);
        wait_done(1'b1, exp_a, n, hold_ok);
        chk("dual latency", n, IN_W);
        chk("dual value", int'(a_all), 8'h12);
        exp_a = 8'h12;
        idle_ok = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            if (a_busy || a_done) idle_ok = 1'b0;
        end
        chk("dual single conversion", int'(idle_ok), 1);

        // reset mid-conversion
        @(negedge clk);
        aw = 5'd25;
        @(posedge clk); #1;
        chk("rstmid accept_busy", int'(a_busy), 1);
        idle_ok = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (a_done) idle_ok = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        if (a_done) idle_ok = 1'b0;
        chk("rstmid no done", int'(idle_ok), 1);
        chk("rstmid a_all", int'(a_all), 0);
        chk("rstmid m_all", int'(m_all), 0);
        chk("rstmid busy", int'(a_busy), 0);
        chk("rstmid ready", int'(a_rdy), 1);
        exp_a = '0;
        exp_m = '0;
        @(posedge clk); #1;
        chk("rstmid reconvert busy", int'(a_busy), 1);
        wait_done(1'b1, exp_a, n, hold_ok);
        chk("rstmid latency", n, IN_W);
        chk("rstmid hold", int'(hold_ok), 1);
        chk("rstmid value", int'(a_all), 8'h25);

        // in_valid held, new w_in presented in the done cycle
        @(negedge clk);
        mw = 5'd19;
        mv = 1'b1;
        @(posedge clk); #1;
        chk("held accept_busy", int'(m_busy), 1);
        wait_done(1'b0, exp_m, n, hold_ok);
        chk("held first latency", n, IN_W);
        chk("held first value", int'(m_all), 8'h19);
        chk("held ready_in_done", int'(m_rdy), 1);
        mw = 5'd20;
        @(posedge clk); #1;
        chk("held restart busy", int'(m_busy), 1);
        wait_done(1'b0, 8'h19, n, hold_ok);
        chk("held second latency", n, IN_W);
        chk("held second hold", int'(hold_ok), 1);
        chk("held second count2", int'(m_c2), 2);
        chk("held second count1", int'(m_c1), 0);
        mv = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
